motorb_relu_seq_ctrl: RTL and testbench
=======================================

// Module: motorb_relu_seq_ctrl
// PURPOSE
//  Sequencer for the ap_fixed<32,8> ReLU activation stage of the motorB network.
//  Captures an N-element activation vector and streams it through LANES shared
//  ReLU lanes, LANES elements per cycle, instead of N parallel comparators.
//  Uses an ap_ctrl_hs-style handshake so it drops in between dense layers.
//  Results are held in a stable output bank until the next completion.
// PARAMETERS
//  N      9   vector length (elements per invocation)
//  W      32  element width, two's-complement fixed point (ap_fixed<32,8>)
//  LANES  1   ReLU lanes per cycle; 1 <= LANES <= N
// PORTS
//  ap_clk          in   1    clock; all logic is on the rising edge
//  ap_rst          in   1    synchronous reset, active-high
//  ap_start        in   1    request a new invocation; sampled only in IDLE/DONE
//  p_read_flat     in   N*W  input vector; element i at [i*W +: W]
//  ap_idle         out  1    1 in IDLE
//  ap_ready        out  1    1-cycle pulse: inputs captured, new start accepted
//  ap_done         out  1    1-cycle pulse: ap_return_flat valid for new result
//  ap_return_flat  out  N*W  result vector; element i at [i*W +: W]
// BEHAVIOUR
//  Reset: state=IDLE, ap_idle=1, ap_ready=0, ap_done=0, ap_return_flat=0,
//   idx=0, internal buffers=0. Reset mid-RUN aborts the invocation: no ap_done,
//   outputs clear to 0.
//  ReLU per element: y = ($signed(x) > 0) ? {1'b0, x[W-2:0]} : 0.
//   x=0 gives 0. The most negative value gives 0. No rounding, no saturation.
//  FSM:
//   IDLE: if ap_start, capture p_read_flat into in_buf, set idx=0,
//    pulse ap_ready, go RUN. Otherwise stay in IDLE.
//   RUN: elements idx..min(idx+LANES,N)-1 pass through ReLU into out_buf.
//    idx += LANES. If the new idx >= N, go DONE. ap_start is ignored here and
//    in_buf is not re-sampled.
//   DONE (1 cycle): ap_done=1, ap_return_flat <= out_buf (the complete result).
//    If ap_start=1, capture new inputs, pulse ap_ready in this same cycle,
//    set idx=0, and go RUN (back-to-back). Otherwise go IDLE.
//  ap_idle=0 in RUN and DONE.
//  Latency: ap_start high in IDLE at cycle 0 gives ap_done at cycle
//   ceil(N/LANES)+1. Back-to-back throughput is one result per ceil(N/LANES)+1
//   cycles.
//  When LANES does not divide N, the last RUN cycle processes only N-idx
//   elements. Lanes past N are gated and never written.
//  ap_return_flat changes only on the DONE edge. It holds its value through
//   IDLE and through subsequent RUN cycles.
//  ap_done and ap_ready are single-cycle pulses, never held.
//  idx width is $clog2(N+LANES). It must not wrap.
// TESTING
//  1 Reset: assert ap_rst 2 cycles with ap_start=1 -> ap_idle=1, ap_done=0,
//    ap_return_flat=0.
//  2 Mixed signs, N=9, LANES=1: in = {0x7FFFFFFF, 0x80000000, 0, 1,
//    0xFFFFFFFF, 0x01000000, 0xFF000000, 0x00000100, 0x12345678}
//    -> out = {0x7FFFFFFF, 0, 0, 1, 0, 0x01000000, 0, 0x00000100, 0x12345678};
//    ap_done exactly 10 cycles after start.
//  3 LANES=4, N=9: RUN lasts 3 cycles, ap_done at cycle 4. Results match the
//    scalar ReLU for 1000 random vectors.
//  4 ap_start held high continuously -> ap_ready fires in IDLE and then in each
//    DONE, one ap_done per 10 cycles. Inputs changed during RUN do not affect
//    the pending result.
//  5 Assert ap_rst at RUN cycle 5 -> no ap_done, ap_return_flat=0. A fresh
//    start afterwards completes normally.
//  6 Hold check: after ap_done, start a new vector with all negative elements.
//    ap_return_flat keeps the previous result until the next ap_done, then
//    becomes all 0.

Source files
------------

// File: rtl/motorb_relu_seq_ctrl.sv
// ReLU sequencer for the motorB ap_fixed<32,8> activation stage: captures an
// N-element vector and pushes it through LANES shared ReLU lanes per cycle.
module motorb_relu_seq_ctrl #(
    parameter int unsigned N     = 9,
    parameter int unsigned W     = 32,
    parameter int unsigned LANES = 1
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
    input  logic           ap_start,
    input  logic [N*W-1:0] p_read_flat,
    output logic           ap_idle,
    output logic           ap_ready,
    output logic           ap_done,
    output logic [N*W-1:0] ap_return_flat
);

    localparam int unsigned NW = N * W;
    localparam int unsigned IW = $clog2(N + LANES);
    localparam logic [IW-1:0] N_IW     = IW'(N);
    localparam logic [IW-1:0] LANES_IW = IW'(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NW-1:0]   in_buf_q, in_buf_d;
    logic [NW-1:0]   out_buf_q, out_buf_d;
    logic [NW-1:0]   ret_q, ret_d;
    logic            done_q, done_d;
    logic            idle_q, idle_d;
    logic            ready_c;

    // Positive values pass unchanged; zero and every negative value give 0.
    function automatic logic [W-1:0] relu(input logic [W-1:0] x);
        return (!x[W-1] && (x != '0)) ? {1'b0, x[W-2:0]} : '0;
    endfunction

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            in_buf_q  <= '0;
            out_buf_q <= '0;
            ret_q     <= '0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            in_buf_q  <= in_buf_d;
            out_buf_q <= out_buf_d;
            ret_q     <= ret_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        ret_d     = ret_q;
        done_d    = 1'b0;
        ready_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    in_buf_d = p_read_flat;
                    idx_d    = '0;
                    ready_c  = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Only the elements inside the current lane window are written;
                // lanes that fall past N on the last pass match nothing.
                for (int unsigned i = 0; i < N; i++) begin
                    if ((IW'(i) >= idx_q) && (IW'(i) < idx_q + LANES_IW)) begin
                        out_buf_d[i*W +: W] = relu(in_buf_q[i*W +: W]);
                    end
                end
                idx_d = idx_q + LANES_IW;
                if (idx_d >= N_IW) begin
                    ret_d   = out_buf_d;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ap_start) begin
                    in_buf_d = p_read_flat;
                    idx_d    = '0;
                    ready_c  = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ap_rst) begin
            ready_c = 1'b0;
        end
        idle_d = (state_d == S_IDLE);
    end

    // ap_ready acknowledges ap_start in the same cycle, as the handshake expects.
    assign ap_ready       = ready_c;
    assign ap_idle        = idle_q;
    assign ap_done        = done_q;
    assign ap_return_flat = ret_q;

endmodule

// File: tb/tb_motorb_relu_seq_ctrl.sv
// Scoreboard bench for motorb_relu_seq_ctrl: one instance with LANES=1 and one
// with LANES=4, both N=9, W=32.
module tb_motorb_relu_seq_ctrl;

    localparam int unsigned N  = 9;
    localparam int unsigned W  = 32;
    localparam int unsigned NW = N * W;

    logic          ap_clk;
    logic          ap_rst;
    logic          s1, s4;
    logic [NW-1:0] d1, d4;
    logic          idle1, rdy1, done1;
    logic          idle4, rdy4, done4;
    logic [NW-1:0] ret1, ret4;

    logic [NW-1:0] sb1[$];
    logic [NW-1:0] sb4[$];
    logic [NW-1:0] last1, last4;
    int            pass_cnt;
    int            total_cnt;

    motorb_relu_seq_ctrl #(.N(N), .W(W), .LANES(1)) u_l1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(s1), .p_read_flat(d1),
        .ap_idle(idle1), .ap_ready(rdy1), .ap_done(done1), .ap_return_flat(ret1)
    );

    motorb_relu_seq_ctrl #(.N(N), .W(W), .LANES(4)) u_l4 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(s4), .p_read_flat(d4),
        .ap_idle(idle4), .ap_ready(rdy4), .ap_done(done4), .ap_return_flat(ret4)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Reference ReLU: sign bit set means negative -> 0, otherwise pass through.
    function automatic logic [NW-1:0] relu_vec(input logic [NW-1:0] v);
        logic [NW-1:0] r;
        logic [W-1:0]  e;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            e = v[i*W +: W];
            r[i*W +: W] = e[W-1] ? '0 : e;
        end
        return r;
    endfunction

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(N); i++) begin
            case ($urandom_range(0, 7))
                0:       v[i*W +: W] = 32'h0000_0000;
                1:       v[i*W +: W] = 32'h8000_0000;
                2:       v[i*W +: W] = 32'h7FFF_FFFF;
                3:       v[i*W +: W] = 32'h0000_0001;
                default: v[i*W +: W] = $urandom;
            endcase
        end
        return v;
    endfunction

    // Start one invocation on the chosen instance and check it end to end.
    task automatic run_vec(input bit use4, input logic [NW-1:0] vec,
                           input logic [NW-1:0] exp_in, input string name);
        logic [NW-1:0] prev, exp_v, r;
        int            lat, done_k;
        bit            hold_ok, dn;
        lat     = use4 ? 4 : 10;
        prev    = use4 ? last4 : last1;
        done_k  = 0;
        hold_ok = 1'b1;
        @(negedge ap_clk);
        if (use4) begin d4 = vec; s4 = 1'b1; sb4.push_back(exp_in); end
        else      begin d1 = vec; s1 = 1'b1; sb1.push_back(exp_in); end
        #1;
        total_cnt++;
        if ((use4 ? rdy4 : rdy1) !== 1'b1)
            $display("FAIL %s ready: got %b want 1", name, use4 ? rdy4 : rdy1);
        else pass_cnt++;
        for (int k = 1; k <= lat + 4; k++) begin
            @(negedge ap_clk);
            dn = use4 ? done4 : done1;
            r  = use4 ? ret4 : ret1;
            // Inputs wiggle during RUN; the captured vector must not change.
            if (use4) begin s4 = 1'b0; d4 = rand_vec(); end
            else      begin s1 = 1'b0; d1 = rand_vec(); end
            if (dn === 1'b1) begin
                done_k = k;
                break;
            end
            if (r !== prev) hold_ok = 1'b0;
        end
        exp_v = use4 ? ((sb4.size() != 0) ? sb4.pop_front() : '0)
                     : ((sb1.size() != 0) ? sb1.pop_front() : '0);
        r = use4 ? ret4 : ret1;
        total_cnt++;
        if (done_k != lat) $display("FAIL %s latency: got %0d want %0d", name, done_k, lat);
        else pass_cnt++;
        total_cnt++;
        if (r !== exp_v) $display("FAIL %s result: got %h want %h", name, r, exp_v);
        else pass_cnt++;
        total_cnt++;
        if (!hold_ok) $display("FAIL %s hold_prev: got changed want %h", name, prev);
        else pass_cnt++;
        @(negedge ap_clk);
        total_cnt++;
        if ((use4 ? done4 : done1) !== 1'b0)
            $display("FAIL %s done_pulse: got %b want 0", name, use4 ? done4 : done1);
        else pass_cnt++;
        total_cnt++;
        if ((use4 ? ret4 : ret1) !== exp_v || (use4 ? idle4 : idle1) !== 1'b1)
            $display("FAIL %s idle_hold: got ret %h idle %b want %h idle 1", name,
                     use4 ? ret4 : ret1, use4 ? idle4 : idle1, exp_v);
        else pass_cnt++;
        if (use4) last4 = exp_v; else last1 = exp_v;
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1; s1 = 1'b1; s4 = 1'b1; d1 = rand_vec(); d4 = rand_vec();
        repeat (2) @(negedge ap_clk);
        total_cnt++;
        if (idle1 !== 1'b1 || done1 !== 1'b0 || rdy1 !== 1'b0)
            $display("FAIL reset_l1 ctl: got idle %b done %b ready %b want 1 0 0", idle1, done1, rdy1);
        else pass_cnt++;
        total_cnt++;
        if (ret1 !== '0) $display("FAIL reset_l1 ret: got %h want 0", ret1);
        else pass_cnt++;
        total_cnt++;
        if (idle4 !== 1'b1 || done4 !== 1'b0 || ret4 !== '0)
            $display("FAIL reset_l4: got idle %b done %b ret %h want 1 0 0", idle4, done4, ret4);
        else pass_cnt++;
        ap_rst = 1'b0; s1 = 1'b0; s4 = 1'b0;
        last1 = '0; last4 = '0;
    endtask

    task automatic test_mixed();
        logic [W-1:0]  vin [9];
        logic [W-1:0]  vout[9];
        logic [NW-1:0] v, e;
        vin  = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h1, 32'hFFFFFFFF,
                 32'h01000000, 32'hFF000000, 32'h00000100, 32'h12345678};
        vout = '{32'h7FFFFFFF, 32'h0, 32'h0, 32'h1, 32'h0,
                 32'h01000000, 32'h0, 32'h00000100, 32'h12345678};
        for (int i = 0; i < 9; i++) begin
            v[i*W +: W] = vin[i];
            e[i*W +: W] = vout[i];
        end
        run_vec(1'b0, v, e, "mixed_l1");
        run_vec(1'b1, v, e, "mixed_l4");
    endtask

    task automatic test_lanes4_random();
        logic [NW-1:0] v;
        for (int n = 0; n < 1000; n++) begin
            v = rand_vec();
            run_vec(1'b1, v, relu_vec(v), "rand_l4");
        end
    endtask

    task automatic test_back_to_back();
        logic [NW-1:0] v, e;
        bit rdy_ok, done_ok, idle_ok, hold_ok;
        int ndone;
        rdy_ok = 1; done_ok = 1; idle_ok = 1; hold_ok = 1; ndone = 0;
        @(negedge ap_clk);
        v = rand_vec(); d1 = v; s1 = 1'b1; sb1.push_back(relu_vec(v));
        #1;
        total_cnt++;
        if (rdy1 !== 1'b1) $display("FAIL b2b ready_idle: got %b want 1", rdy1);
        else pass_cnt++;
        for (int c = 1; c <= 30; c++) begin
            @(negedge ap_clk);
            if (rdy1 !== ((c % 10) == 0)) rdy_ok = 0;
            if (done1 !== ((c % 10) == 0)) done_ok = 0;
            if (idle1 !== 1'b0) idle_ok = 0;
            if (done1 === 1'b1) begin
                ndone++;
                e = (sb1.size() != 0) ? sb1.pop_front() : '0;
                total_cnt++;
                if (ret1 !== e) $display("FAIL b2b result: got %h want %h", ret1, e);
                else pass_cnt++;
                last1 = e;
            end else if (ret1 !== last1) begin
                hold_ok = 0;
            end
            v = rand_vec(); d1 = v;
            if ((c % 10) == 0) begin
                if (c < 30) sb1.push_back(relu_vec(v));
                else        s1 = 1'b0;
            end
        end
        total_cnt++;
        if (!rdy_ok) $display("FAIL b2b ready_pattern: got mismatch want pulse every 10");
        else pass_cnt++;
        total_cnt++;
        if (!done_ok || ndone != 3) $display("FAIL b2b done_pattern: got %0d dones want 3", ndone);
        else pass_cnt++;
        total_cnt++;
        if (!idle_ok || !hold_ok) $display("FAIL b2b idle_hold: got idle_ok %b hold_ok %b want 1 1", idle_ok, hold_ok);
        else pass_cnt++;
        @(negedge ap_clk);
        total_cnt++;
        if (idle1 !== 1'b1 || sb1.size() != 0)
            $display("FAIL b2b end: got idle %b pending %0d want 1 0", idle1, sb1.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [NW-1:0] v;
        bit quiet;
        quiet = 1;
        @(negedge ap_clk);
        d1 = rand_vec(); s1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge ap_clk);
            s1 = 1'b0;
        end
        total_cnt++;
        if (idle1 !== 1'b0) $display("FAIL rst_mid in_run: got idle %b want 0", idle1);
        else pass_cnt++;
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (done1 !== 1'b0 || ret1 !== '0 || idle1 !== 1'b1) quiet = 0;
            @(negedge ap_clk);
        end
        total_cnt++;
        if (!quiet) $display("FAIL rst_mid abort: got done/ret activity want none, ret %h", ret1);
        else pass_cnt++;
        last1 = '0; last4 = '0;
        v = rand_vec();
        run_vec(1'b0, v, relu_vec(v), "rst_mid_fresh");
    endtask

    task automatic test_hold();
        logic [NW-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i*W +: W] = 32'h0000_1000 + 32'(i);
        run_vec(1'b0, v, v, "hold_pos");
        for (int i = 0; i < int'(N); i++) v[i*W +: W] = 32'hF000_0000 | 32'(i);
        run_vec(1'b0, v, '0, "hold_neg");
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        ap_rst = 1'b1; s1 = 1'b0; s4 = 1'b0; d1 = '0; d4 = '0;
        last1 = '0; last4 = '0;
        test_reset();
        test_mixed();
        test_lanes4_random();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
